// File: rtl/ars_proj2aff.sv
// ars_proj2aff -- projective-to-affine x-coordinate conversion over GF(2^233)
//
// Computes x_aff = X * Z^-1 mod f(t), f(t) = t^233 + t^74 + 1, for the output
// of the Lopez-Dahab ladder before the signature r-computation stage.
// Z^-1 is formed with the Fermat chain Z^(2^233-2) = prod_{i=1..232} Z^(2^i):
// the running power t is squared once per round and multiplied into acc.
// All multiplies go through one shared multiplier with a registered
// mul_en / ready handshake; squarings are purely combinational.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous active-high reset, clears every register
//   start  one-cycle request, sampled only in IDLE or DONE
//   X, Z   projective coordinates, captured on an accepted start
//   busy   high from the cycle after an accepted start until done rises
//   done   level, high from completion until the next accepted start or rst
//   x_aff  affine x, valid while done=1
//   inf    Z was zero (only with ARS_P2A_INF_DETECT_EN, otherwise tied 0)
//
// Build option
//   ARS_P2A_INF_DETECT_EN : when defined, Z==0 is caught in LOAD and the
//   block goes straight to DONE with x_aff=0 and inf=1. When undefined, Z==0
//   runs the full chain and naturally yields x_aff=0.

module ars_proj2aff #(
  parameter int M = 233
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] X,
  input  logic [M-1:0] Z,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] x_aff,
  output logic         inf
);

  // Middle term of the reduction polynomial and t^M mod f = t^K + 1.
  localparam int           K        = 74;
  localparam logic [M-1:0] RED      = (M)'(1) | ((M)'(1) << K);
  localparam logic [7:0]   CNT_INIT = 8'(M - 2);

  // Fixed latency of the shared multiplier: number of edges that sample
  // mul_en=1, the last of which also samples ready=1.
  localparam int         MUL_LAT  = 3;
  localparam logic [1:0] LAT_LAST = 2'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQR,
    S_MUL,
    S_FINAL,
    S_DONE
  } state_t;

  state_t       state, nstate;
  logic [7:0]   cnt;
  logic         mul_en;
  logic [1:0]   mcnt;
  logic         mul_rdy;
  logic         fin_arm;

  logic [M-1:0] Xr, Zr, t, acc;
  logic [M-1:0] mul_a, mul_b, mul_p;
  logic [M-1:0] sq_z, sq_t;

  logic         op_ld, t_ld_z, t_ld_t, men_set, cap, cap_mul, fin_arm_set, pub;
`ifdef ARS_P2A_INF_DETECT_EN
  logic         inf_hit;
  logic         inf_q;
`endif

  // Multiply modulo f: MSB-first shift-and-add, folding t^M back as t^K + 1.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b);
    logic [M-1:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = r[M-1] ? ({r[M-2:0], 1'b0} ^ RED) : {r[M-2:0], 1'b0};
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  // Squaring in GF(2^m) only spreads the bits (a_i -> position 2i); the
  // high half is then folded down from the top so cascaded folds are caught.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-2:0] s;
    s = '0;
    for (int i = 0; i < M; i++) s[2*i] = a[i];
    for (int j = 2*M - 2; j >= M; j--) begin
      if (s[j]) begin
        s[j-M+K] = ~s[j-M+K];
        s[j-M]   = ~s[j-M];
      end
    end
    return s[M-1:0];
  endfunction

  assign sq_z = gf_sq(Zr);
  assign sq_t = gf_sq(t);

  // Shared multiplier: operands are held stable by the FSM while mul_en=1.
  assign mul_a   = acc;
  assign mul_b   = (state == S_FINAL) ? Xr : t;
  assign mul_p   = gf_mul(mul_a, mul_b);
  assign mul_rdy = mul_en && (mcnt == LAT_LAST);

  // Next-state and per-cycle control strobes.
  always_comb begin
    nstate      = state;
    op_ld       = 1'b0;
    t_ld_z      = 1'b0;
    t_ld_t      = 1'b0;
    men_set     = 1'b0;
    cap         = 1'b0;
    cap_mul     = 1'b0;
    fin_arm_set = 1'b0;
    pub         = 1'b0;
`ifdef ARS_P2A_INF_DETECT_EN
    inf_hit     = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          op_ld  = 1'b1;
          nstate = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef ARS_P2A_INF_DETECT_EN
        if (Zr == '0) begin
          inf_hit = 1'b1;
          nstate  = S_DONE;
        end else begin
          t_ld_z = 1'b1;
          nstate = S_SQR;
        end
`else
        t_ld_z = 1'b1;
        nstate = S_SQR;
`endif
      end
      S_SQR: begin
        t_ld_t = 1'b1;
        nstate = S_MUL;
      end
      S_MUL: begin
        if (!mul_en) begin
          men_set = 1'b1;
        end else if (mul_rdy) begin
          cap     = 1'b1;
          cap_mul = 1'b1;
          nstate  = (cnt == 8'd1) ? S_FINAL : S_SQR;
        end
      end
      S_FINAL: begin
        // First cycle lets the operand mux settle on Xr with mul_en low,
        // mirroring the SQR gap that precedes every chain multiply.
        if (!fin_arm) begin
          fin_arm_set = 1'b1;
        end else if (!mul_en) begin
          men_set = 1'b1;
        end else if (mul_rdy) begin
          cap    = 1'b1;
          nstate = S_DONE;
        end
      end
      S_DONE: begin
        // Publish on the entry cycle (busy is still high, so start is
        // ignored there); afterwards a start restarts with new operands.
        if (!done) begin
          pub = 1'b1;
        end else if (start) begin
          op_ld  = 1'b1;
          nstate = S_LOAD;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mul_en  <= 1'b0;
      mcnt    <= '0;
      fin_arm <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= nstate;

      if (t_ld_z)       cnt <= CNT_INIT;
      else if (cap_mul) cnt <= cnt - 8'd1;

      if (men_set)  mul_en <= 1'b1;
      else if (cap) mul_en <= 1'b0;

      if (mul_en && !mul_rdy) mcnt <= mcnt + 2'd1;
      else                    mcnt <= '0;

      if (fin_arm_set) fin_arm <= 1'b1;
      else if (cap)    fin_arm <= 1'b0;

      if (op_ld) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (pub) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  // Field datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      Xr    <= '0;
      Zr    <= '0;
      t     <= '0;
      acc   <= '0;
      x_aff <= '0;
    end else begin
      if (op_ld) begin
        Xr <= X;
        Zr <= Z;
      end
      if (t_ld_z) begin
        t   <= sq_z;
        acc <= sq_z;
      end
      if (t_ld_t) t   <= sq_t;
      if (cap)    acc <= mul_p;
`ifdef ARS_P2A_INF_DETECT_EN
      if (inf_hit) acc <= '0;
`endif
      if (pub) x_aff <= acc;
    end
  end

`ifdef ARS_P2A_INF_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst)          inf_q <= 1'b0;
    else if (op_ld)   inf_q <= 1'b0;
    else if (inf_hit) inf_q <= 1'b1;
  end
  assign inf = inf_q;
`else
  assign inf = 1'b0;
`endif

endmodule

// File: tb/tb_ars_proj2aff.sv
module tb_ars_proj2aff;

  localparam int M        = 233;
  localparam int LAT_FULL = 1162;
`ifdef ARS_P2A_INF_DETECT_EN
  localparam int  LAT_Z0 = 2;
  localparam logic INF_Z0 = 1'b1;
`else
  localparam int  LAT_Z0 = LAT_FULL;
  localparam logic INF_Z0 = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [M-1:0] x_in = '0;
  logic [M-1:0] z_in = '0;
  logic         busy, done, inf;
  logic [M-1:0] x_aff;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [M-1:0] x;
    logic         inf;
    int           sc;
    int           lat;
  } exp_t;
  exp_t sb[$];

  ars_proj2aff #(.M(M)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (x_in),
    .Z     (z_in),
    .busy  (busy),
    .done  (done),
    .x_aff (x_aff),
    .inf   (inf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model: polynomial arithmetic mod f ----------
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [511:0] p, f, aa;
    p = '0; f = '0; f[233] = 1'b1; f[74] = 1'b1; f[0] = 1'b1;
    aa = '0; aa[M-1:0] = a;
    for (int i = 0; i < M; i++) if (b[i]) p = p ^ (aa << i);
    for (int j = 2*M - 2; j >= M; j--) if (p[j]) p = p ^ (f << (j - M));
    return p[M-1:0];
  endfunction

  function automatic int deg(input logic [255:0] v);
    for (int i = 255; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Extended Euclid on binary polynomials: keeps g1*a == u (mod f).
  function automatic logic [M-1:0] ref_inv(input logic [M-1:0] a);
    logic [255:0] u, v, g1, g2, tmp;
    int j;
    int guard;
    if (a == '0) return '0;
    u = '0; u[M-1:0] = a;
    v = '0; v[233] = 1'b1; v[74] = 1'b1; v[0] = 1'b1;
    g1 = 256'd1; g2 = '0; guard = 0;
    while (u != 256'd1 && guard < 4000) begin
      j = deg(u) - deg(v);
      if (j < 0) begin
        tmp = u; u = v; v = tmp;
        tmp = g1; g1 = g2; g2 = tmp;
        j = -j;
      end
      u  = u ^ (v << j);
      g1 = g1 ^ (g2 << j);
      guard++;
    end
    return g1[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_fe();
    logic [255:0] tmp;
    for (int w = 0; w < 8; w++) tmp[w*32 +: 32] = $urandom;
    if (tmp[M-1:0] == '0) tmp[0] = 1'b1;
    return tmp[M-1:0];
  endfunction

  // ---------------- monitor: pops expectations when done rises ------------
  logic done_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("x_aff", x_aff, e.x);
          chk("inf", M'(inf), M'(e.inf));
          chk("latency", M'(cyc - e.sc), M'(e.lat));
        end
      end
      done_q <= done;
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic issue(input logic [M-1:0] xv, input logic [M-1:0] zv,
                       input logic [M-1:0] ex, input logic ei, input int el,
                       input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; x_in = xv; z_in = zv;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e.x = ex; e.inf = ei; e.sc = cyc; e.lat = el;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int mid_at, input logic [M-1:0] x2, input logic [M-1:0] z2);
    int low = 0;
    bit got = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == mid_at) begin start = 1'b1; x_in = x2; z_in = z2; end
      else if (i == mid_at + 1) start = 1'b0;
      if (done) begin got = 1; break; end
      if (!busy) low++;
      x_in = rand_fe(); z_in = rand_fe();
    end
    start = 1'b0;
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout: got done=0 expected done within 3000 cycles");
    end
    chk("busy_held", M'(low), M'(0));
  endtask

  task automatic run(input logic [M-1:0] xv, input logic [M-1:0] zv,
                     input logic [M-1:0] ex, input logic ei, input int el);
    issue(xv, zv, ex, ei, el, 1'b1);
    wait_done(-5, '0, '0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] a, b, xv, zv, e;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", M'(busy), M'(0));
    chk("rst_done", M'(done), M'(0));
    chk("rst_x_aff", x_aff, '0);
    chk("rst_inf", M'(inf), M'(0));
    @(negedge clk); rst = 1'b0;

    // Identity: Z=1 gives X back.
    xv = '0; xv[0] = 1'b1;
    run(xv, xv, xv, 1'b0, LAT_FULL);

    // Inverse of t is t^232 + t^73.
    zv = '0; zv[1] = 1'b1;
    e = '0; e[232] = 1'b1; e[73] = 1'b1;
    run(xv, zv, e, 1'b0, LAT_FULL);

    // X=Z=A -> 1, then X=A*B, Z=B -> A.
    for (int r = 0; r < 3; r++) begin
      a = rand_fe(); b = rand_fe();
      run(a, a, xv, 1'b0, LAT_FULL);
      run(ref_mul(a, b), b, a, 1'b0, LAT_FULL);
    end

    // Fully random operands against the Euclid-based model.
    for (int r = 0; r < 2; r++) begin
      a = rand_fe(); b = rand_fe();
      run(a, b, ref_mul(a, ref_inv(b)), 1'b0, LAT_FULL);
    end

    // Z=0.
    xv = '0; xv[0] = 1'b1; xv[2] = 1'b1;
    run(xv, '0, '0, INF_Z0, LAT_Z0);

    // A nonzero result so the abort has something to clear.
    a = rand_fe(); b = rand_fe();
    run(a, b, ref_mul(a, ref_inv(b)), 1'b0, LAT_FULL);

    // Reset 500 cycles into a run.
    issue(rand_fe(), rand_fe(), '0, 1'b0, 0, 1'b0);
    repeat (499) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", M'(busy), M'(0));
    chk("abort_done", M'(done), M'(0));
    chk("abort_x_aff", x_aff, '0);
    chk("abort_inf", M'(inf), M'(0));
    @(negedge clk); rst = 1'b0;
    a = rand_fe(); b = rand_fe();
    run(a, b, ref_mul(a, ref_inv(b)), 1'b0, LAT_FULL);

    // start mid-run with other operands is ignored.
    a = rand_fe(); b = rand_fe();
    issue(a, b, ref_mul(a, ref_inv(b)), 1'b0, LAT_FULL, 1'b1);
    wait_done(300, rand_fe(), rand_fe());

    // start while in DONE restarts with the new operands.
    repeat (4) @(negedge clk);
    a = rand_fe(); b = rand_fe();
    issue(a, b, ref_mul(a, ref_inv(b)), 1'b0, LAT_FULL, 1'b1);
    chk("done_drop", M'(done), M'(0));
    wait_done(-5, '0, '0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", M'(sb.size()), M'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ars_proj2aff.md
Name: ars_proj2aff

Overview:
- Downstream consumer of the López-Dahab point-addition/doubling ladder over GF(2^233) in the ECC sign datapath.
- Converts a projective x-coordinate (X, Z) to affine form: x_aff = X · Z^-1 mod f(t), with f(t) = t^233 + t^74 + 1.
- Inversion uses the Fermat chain Z^(2^233−2) = ∏_{i=1..232} Z^(2^i). One shared ARS_mult_ip instance does all multiplies; combinational ARS_squar instances do all squarings.
- Output feeds the signature r-computation stage.

Parameters:
- M, 233, field degree. Only 233 is supported and verified; it sets operand widths and the iteration count M−2 = 231.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request. Sampled only in IDLE or DONE.
- X  input  233  projective X. Captured on the accepted start.
- Z  input  233  projective Z. Captured on the accepted start.
- busy  output  1  high from the cycle after an accepted start until done rises
- done  output  1  level. High from completion until the next accepted start or rst.
- x_aff  output  233  affine x. Valid while done=1.
- inf  output  1  Z was zero (see Optional Feature)

Behaviour:
- Reset: on rst=1 at a clock edge, go to IDLE and clear every register. Outputs: busy=0, done=0, x_aff=0, inf=0, mult enable=0, counter=0. Reset mid-computation aborts immediately. No partial result is exposed.
- Multiplier handshake:
  - mul_en is registered.
  - Operands stay stable while mul_en=1.
  - On the cycle ready=1, the product is captured and mul_en drops at the same edge.
  - mul_en stays low for at least 1 cycle before the next multiply.
  - L = number of cycles from the first edge sampling mul_en=1 to the edge sampling ready=1.
- Operand mux: mul_a = acc; mul_b = Xr in FINAL, otherwise t.
- FSM states and transitions:
  - IDLE: on start, Xr<=X, Zr<=Z, busy<=1, go to LOAD.
  - LOAD (1 cycle): t<=sq(Zr), acc<=sq(Zr), cnt<=231, go to SQR.
  - SQR (1 cycle): t<=sq(t), go to MUL.
  - MUL:
    - First cycle: mul_en<=1.
    - Wait for ready, then acc<=product and mul_en<=0.
    - cnt<=cnt−1. If the result is 0, go to FINAL; otherwise go to SQR.
  - FINAL: same handshake as MUL with operand Xr. acc<=product, go to DONE.
  - DONE: x_aff<=acc on entry, done=1, busy=0. Holds until start (re-enter LOAD path with new operands, done<=0) or rst.
- Latency: done rises 2 + 231·(L+2) + (L+1) + 1 cycles after the accepted start edge. This is 1162 cycles for L=3.
- start while busy=1 is ignored, with no effect on state or operands.
- start and rst in the same cycle: rst wins.
- X, Z changing after acceptance have no effect.
- Arithmetic is GF(2^233) only. Addition is XOR. No integer carries.
- cnt is 8 bits, with no wrap: it is loaded to 231 and exits at 0.

Optional Feature:
- Macro: ARS_P2A_INF_DETECT_EN.
- Defined:
  - On LOAD, test Zr==0. If true, skip directly to DONE with x_aff=0 and inf=1.
  - Latency is 2 cycles.
  - inf clears on the next accepted start or rst.
- Undefined:
  - inf is tied to 0.
  - Z=0 runs the full chain and yields x_aff=0 at the normal latency.

Test Plan:
- X=1, Z=1, mock multiplier L=3 -> x_aff=1; done rises exactly 1162 cycles after start; busy high throughout.
- X=1, Z=2 (t) -> x_aff = bit232 | bit73 (i.e. t^232+t^73 = t^-1 mod f).
- X=Z=random nonzero A -> x_aff=1. Then X=A·B mod f, Z=B -> x_aff=A (checked against a software model).
- Z=0, X=5: with ARS_P2A_INF_DETECT_EN defined -> inf=1, x_aff=0, done after 2 cycles. Without the macro -> inf=0, x_aff=0 at full latency.
- rst pulsed at cycle 500 of an operation -> next cycle busy=0, done=0, x_aff=0. A new start is then accepted and completes correctly.
- start pulsed again mid-run with different X/Z -> ignored; result matches the first operands. start during DONE -> done drops next cycle and the new result is produced.
